// File: rtl/grid_pkg.sv
// Shared types and helpers for the grid puzzle engine.
// Optional feature macro used by the core: UNDO_EN.
package grid_pkg;

  typedef enum logic [1:0] {StIdle, StScramble, StFixup} state_e;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Wide enough to hold any line index and GRID_N itself (GRID_N <= 8).
  localparam int unsigned MAX_IDX_W = 4;

  typedef struct packed {
    logic                 is_col;
    logic [MAX_IDX_W-1:0] index;
    logic                 sub;
  } move_t;

  function automatic int unsigned idx_width(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/grid_puzzle_core_if.sv
// User move command handshake between input conditioning and the puzzle core.
interface grid_puzzle_core_if #(
  parameter int unsigned IDX_W = 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_is_col;
  logic [IDX_W-1:0] cmd_index;
  logic             cmd_sub;

  modport master (output cmd_valid, cmd_is_col, cmd_index, cmd_sub, input cmd_ready);
  modport slave  (input cmd_valid, cmd_is_col, cmd_index, cmd_sub, output cmd_ready);
endinterface

// File: rtl/grid_lfsr.sv
// Free-running 16-bit Galois LFSR (right shift, mask 16'hB400); reloads SEED on reset.
module grid_lfsr
  import grid_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);
  logic [15:0] state_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= SEED;
    else       state_q <= (state_q >> 1) ^ (state_q[0] ? LFSR_MASK : 16'h0000);
  end

  assign state = state_q;
endmodule

// File: rtl/grid_puzzle_core.sv
// N x N modular cell engine: row/column fire moves, LFSR scramble, solved flag, move counter.
// Define UNDO_EN to build the single-level undo of the last user move.
module grid_puzzle_core
  import grid_pkg::*;
#(
  parameter int unsigned GRID_N         = 4,
  parameter int unsigned STATE_BITS     = 2,
  parameter int unsigned SCRAMBLE_MOVES = 16,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int unsigned MOVE_CNT_W     = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  grid_puzzle_core_if.slave                    cmd,
  input  logic                                 scramble_start,
  input  logic                                 undo,
  output logic                                 busy,
  output logic [GRID_N*GRID_N*STATE_BITS-1:0]  cells,
  output logic                                 solved,
  output logic [MOVE_CNT_W-1:0]                move_count
);
  localparam int unsigned IDX_W   = idx_width(GRID_N);
  localparam int unsigned CELLS_W = GRID_N * GRID_N * STATE_BITS;
  localparam logic [MAX_IDX_W-1:0] N_IDX = MAX_IDX_W'(GRID_N);

  state_e                state_q, state_d;
  logic [CELLS_W-1:0]    cells_q, cells_d;
  logic                  solved_q;
  logic [MOVE_CNT_W-1:0] move_q, move_d;
  logic [7:0]            scr_q, scr_d;
  logic [15:0]           lfsr;
  logic                  ready, apply;
  move_t                 mv;
  logic [MAX_IDX_W-1:0]  cmd_idx, scr_raw, scr_idx;
  logic                  unused_bits;

`ifdef UNDO_EN
  move_t rec_q, rec_d;
  logic  rec_valid_q, rec_valid_d;
  assign unused_bits = ^lfsr[14:IDX_W];
`else
  assign unused_bits = ^{undo, lfsr[14:IDX_W]};
`endif

  grid_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .reset(reset), .state(lfsr));

  function automatic logic is_uniform(logic [CELLS_W-1:0] g);
    is_uniform = 1'b1;
    for (int unsigned i = 1; i < GRID_N * GRID_N; i++) begin
      if (g[i*STATE_BITS +: STATE_BITS] != g[STATE_BITS-1:0]) is_uniform = 1'b0;
    end
  endfunction

  function automatic logic [CELLS_W-1:0] apply_move(logic [CELLS_W-1:0] g, move_t m);
    logic hit;
    apply_move = g;
    for (int unsigned r = 0; r < GRID_N; r++) begin
      for (int unsigned c = 0; c < GRID_N; c++) begin
        hit = m.is_col ? (m.index == MAX_IDX_W'(c)) : (m.index == MAX_IDX_W'(r));
        if (hit) begin
          apply_move[(r*GRID_N+c)*STATE_BITS +: STATE_BITS] = m.sub
            ? g[(r*GRID_N+c)*STATE_BITS +: STATE_BITS] - STATE_BITS'(1)
            : g[(r*GRID_N+c)*STATE_BITS +: STATE_BITS] + STATE_BITS'(1);
        end
      end
    end
  endfunction

  always_comb begin
    state_d = state_q;
    move_d  = move_q;
    scr_d   = scr_q;
    apply   = 1'b0;
    mv      = '0;
    ready   = 1'b0;
`ifdef UNDO_EN
    rec_d       = rec_q;
    rec_valid_d = rec_valid_q;
`endif
    cmd_idx = MAX_IDX_W'(cmd.cmd_index);
    scr_raw = MAX_IDX_W'(lfsr[IDX_W-1:0]);
    scr_idx = (scr_raw >= N_IDX) ? scr_raw - N_IDX : scr_raw;

    unique case (state_q)
      StIdle: begin
        ready = !scramble_start;
`ifdef UNDO_EN
        if (undo) ready = 1'b0;
`endif
        if (scramble_start) begin
          state_d = StScramble;
          move_d  = '0;
          scr_d   = 8'(SCRAMBLE_MOVES);
`ifdef UNDO_EN
          rec_valid_d = 1'b0;
        end else if (undo) begin
          if (rec_valid_q) begin
            apply       = 1'b1;
            mv          = rec_q;
            mv.sub      = ~rec_q.sub;
            rec_valid_d = 1'b0;
            if (move_q != '0) move_d = move_q - MOVE_CNT_W'(1);
          end
`endif
        end else if (cmd.cmd_valid && ready && cmd_idx < N_IDX) begin
          // Out-of-range indices are accepted but have no effect.
          apply     = 1'b1;
          mv.is_col = cmd.cmd_is_col;
          mv.index  = cmd_idx;
          mv.sub    = cmd.cmd_sub;
          if (move_q != '1) move_d = move_q + MOVE_CNT_W'(1);
`ifdef UNDO_EN
          rec_d       = mv;
          rec_valid_d = 1'b1;
`endif
        end
      end
      StScramble: begin
        apply     = 1'b1;
        mv.is_col = lfsr[15];
        mv.index  = scr_idx;
        scr_d     = scr_q - 8'd1;
        if (scr_q <= 8'd1) state_d = StFixup;
      end
      StFixup: begin
        // A scramble must never leave the puzzle already solved.
        apply   = is_uniform(cells_q);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    cells_d = apply ? apply_move(cells_q, mv) : cells_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cells_q  <= '0;
      solved_q <= 1'b1;
      move_q   <= '0;
      scr_q    <= '0;
`ifdef UNDO_EN
      rec_q       <= '0;
      rec_valid_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cells_q  <= cells_d;
      solved_q <= is_uniform(cells_q);
      move_q   <= move_d;
      scr_q    <= scr_d;
`ifdef UNDO_EN
      rec_q       <= rec_d;
      rec_valid_q <= rec_valid_d;
`endif
    end
  end

  assign cmd.cmd_ready = ready;
  assign busy          = (state_q != StIdle);
  assign cells         = cells_q;
  assign solved        = solved_q;
  assign move_count    = move_q;
endmodule

// File: tb/tb_grid_puzzle_core.sv
// Directed bench for grid_puzzle_core (4x4, 2-bit cells); UNDO_EN selects the undo checks.
module tb_grid_puzzle_core;
  localparam int M = 16;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        scramble_start = 1'b0;
  logic        undo = 1'b0;
  logic        busy, solved;
  logic [31:0] cells;
  logic [15:0] move_count;

  int          total = 0;
  int          bad = 0;
  logic [15:0] m_lfsr;
  logic [1:0]  mg [4][4];

  grid_puzzle_core_if #(.IDX_W(2)) cmd_if ();

  grid_puzzle_core dut (
    .clk           (clk),
    .reset         (reset),
    .cmd           (cmd_if.slave),
    .scramble_start(scramble_start),
    .undo          (undo),
    .busy          (busy),
    .cells         (cells),
    .solved        (solved),
    .move_count    (move_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] lfsr_step(logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  function automatic logic [31:0] mpack();
    logic [31:0] v;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) v[(r*4+c)*2 +: 2] = mg[r][c];
    return v;
  endfunction

  function automatic logic m_uniform();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) if (mg[r][c] != mg[0][0]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_move(logic col, int idx, logic sub);
    for (int k = 0; k < 4; k++) begin
      if (col) mg[k][idx] = sub ? mg[k][idx] - 2'd1 : mg[k][idx] + 2'd1;
      else     mg[idx][k] = sub ? mg[idx][k] - 2'd1 : mg[idx][k] + 2'd1;
    end
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_lfsr = reset ? SEED : lfsr_step(m_lfsr);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) mg[r][c] = 2'd0;
  endtask

  task automatic fire(logic col, logic [1:0] idx, logic sub);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_is_col = col;
    cmd_if.cmd_index  = idx;
    cmd_if.cmd_sub    = sub;
    tick();
    cmd_if.cmd_valid = 1'b0;
    model_move(col, int'(idx), sub);
  endtask

  initial begin
    int busy_cnt;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_is_col = 1'b0;
    cmd_if.cmd_index  = 2'd0;
    cmd_if.cmd_sub    = 1'b0;

    // Reset state
    do_reset();
    check("rst_cells", 64'(cells), 64'h0);
    check("rst_solved", 64'(solved), 64'h1);
    check("rst_moves", 64'(move_count), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_ready", 64'(cmd_if.cmd_ready), 64'h1);
    check("rst_lfsr", 64'(dut.lfsr), 64'(SEED));

    // Row 1 add
    fire(1'b0, 2'd1, 1'b0);
    check("row1_cells", 64'(cells), 64'h0000_5500);
    check("row1_solved_lag", 64'(solved), 64'h1);
    check("row1_moves", 64'(move_count), 64'h1);
    tick();
    check("row1_solved", 64'(solved), 64'h0);

    // Column 2 subtract then add
    do_reset();
    fire(1'b1, 2'd2, 1'b1);
    check("col2_sub_cells", 64'(cells), 64'h3030_3030);
    fire(1'b1, 2'd2, 1'b0);
    check("col2_add_cells", 64'(cells), 64'h0);
    check("col2_moves", 64'(move_count), 64'h2);
    tick();
    check("col2_solved", 64'(solved), 64'h1);

    // Row 0 wraps after four adds
    do_reset();
    fire(1'b0, 2'd0, 1'b0);
    fire(1'b0, 2'd0, 1'b0);
    check("row0_x2", 64'(cells), 64'h0000_00AA);
    fire(1'b0, 2'd0, 1'b0);
    check("row0_x3", 64'(cells), 64'h0000_00FF);
    fire(1'b0, 2'd0, 1'b0);
    check("row0_wrap", 64'(cells), 64'h0);
    check("row0_moves", 64'(move_count), 64'h4);
    check("row0_solved_lag", 64'(solved), 64'h0);
    tick();
    check("row0_solved", 64'(solved), 64'h1);

    // Scramble, with a colliding cmd_valid that must be refused
    do_reset();
    fire(1'b0, 2'd3, 1'b0);
    check("pre_scr_moves", 64'(move_count), 64'h1);
    scramble_start    = 1'b1;
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_is_col = 1'b1;
    cmd_if.cmd_index  = 2'd0;
    cmd_if.cmd_sub    = 1'b1;
    #1;
    check("scr_ready_low", 64'(cmd_if.cmd_ready), 64'h0);
    tick();
    scramble_start   = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < M; i++) begin
      busy_cnt += int'(busy);
      model_move(m_lfsr[15], int'(m_lfsr[1:0]), 1'b0);
      tick();
    end
    busy_cnt += int'(busy);
    if (m_uniform()) model_move(1'b0, 0, 1'b0);
    tick();
    busy_cnt += int'(busy);
    check("scr_busy_cycles", 64'(busy_cnt), 64'(M + 1));
    check("scr_cells", 64'(cells), 64'(mpack()));
    check("scr_moves", 64'(move_count), 64'h0);
    tick();
    check("scr_solved", 64'(solved), 64'h0);

    // Reset mid-scramble
    do_reset();
    scramble_start = 1'b1;
    tick();
    scramble_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mid_busy_pre", 64'(busy), 64'h1);
    reset = 1'b1;
    tick();
    check("mid_cells", 64'(cells), 64'h0);
    check("mid_busy", 64'(busy), 64'h0);
    check("mid_solved", 64'(solved), 64'h1);
    check("mid_lfsr", 64'(dut.lfsr), 64'(SEED));
    reset = 1'b0;

`ifdef UNDO_EN
    do_reset();
    fire(1'b0, 2'd3, 1'b0);
    check("undo_pre_cells", 64'(cells), 64'h5500_0000);
    undo              = 1'b1;
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_is_col = 1'b0;
    cmd_if.cmd_index  = 2'd1;
    cmd_if.cmd_sub    = 1'b0;
    #1;
    check("undo_ready_low", 64'(cmd_if.cmd_ready), 64'h0);
    tick();
    undo             = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    check("undo_cells", 64'(cells), 64'h0);
    check("undo_moves", 64'(move_count), 64'h0);
    undo = 1'b1;
    tick();
    undo = 1'b0;
    check("undo2_cells", 64'(cells), 64'h0);
    check("undo2_moves", 64'(move_count), 64'h0);
`else
    do_reset();
    fire(1'b0, 2'd3, 1'b0);
    undo              = 1'b1;
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_is_col = 1'b0;
    cmd_if.cmd_index  = 2'd3;
    cmd_if.cmd_sub    = 1'b1;
    #1;
    check("noundo_ready", 64'(cmd_if.cmd_ready), 64'h1);
    tick();
    undo             = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    check("noundo_cells", 64'(cells), 64'h0);
    check("noundo_moves", 64'(move_count), 64'h2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/grid_puzzle_core.md
Name: grid_puzzle_core

Overview:
Parametrised N×N cell-state engine for the tile-puzzle game. Each cell is a modular counter. Row or column "fire" commands add or subtract 1 on every cell in the selected line. Adds a handshaked command port, an autonomous LFSR scramble sequencer, a registered solved flag and a move counter. Sits between input conditioning (debounce/edge-detect) and the colour decoder, VGA display, win-audio and 7-segment blocks.

Parameters:
- GRID_N, 4, cells per row and column (2..8).
- STATE_BITS, 2, bits per cell; arithmetic is mod 2^STATE_BITS.
- SCRAMBLE_MOVES, 16, random moves per scramble batch (1..255).
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
- MOVE_CNT_W, 16, move counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  user move request.
- cmd_ready  out  1  engine accepts a move this cycle.
- cmd_is_col  in  1  0 = row, 1 = column.
- cmd_index  in  IDX_W = max(1, clog2(GRID_N))  line index.
- cmd_sub  in  1  0 = add 1, 1 = subtract 1.
- scramble_start  in  1  single-cycle pulse; starts a scramble.
- undo  in  1  single-cycle pulse; undoes the last user move (used only with UNDO_EN).
- busy  out  1  scramble in progress.
- cells  out  GRID_N*GRID_N*STATE_BITS  cell (r,c) at bits [(r*GRID_N+c)*STATE_BITS +: STATE_BITS].
- solved  out  1  all cells hold the same value.
- move_count  out  MOVE_CNT_W  accepted user moves since the last scramble.

Behaviour:
- Reset values: cells = 0, solved = 1, move_count = 0, busy = 0, FSM = IDLE, LFSR = LFSR_SEED, undo record invalid.
- LFSR: 16-bit Galois, mask 16'hB400. Steps every cycle when not in reset.
- FSM states: IDLE, SCRAMBLE, FIXUP.
- cmd_ready = (state == IDLE) && !scramble_start. This is combinational.
- IDLE, when cmd_valid && cmd_ready:
  - Update cells in the selected line at that clock edge. The new values are visible on the next cycle.
  - Increment move_count, saturating at all-ones.
  - If cmd_index >= GRID_N: accept the command, change no cells, leave move_count unchanged.
- IDLE with scramble_start: go to SCRAMBLE, clear move_count, set busy = 1, load the move counter with SCRAMBLE_MOVES. scramble_start takes priority over a simultaneous cmd_valid, which is not accepted.
- SCRAMBLE: apply one move per cycle with add (never subtract).
  - is_col = lfsr[15].
  - idx = lfsr[IDX_W-1:0]; if idx >= GRID_N, use idx - GRID_N.
  - After SCRAMBLE_MOVES moves, go to FIXUP.
- FIXUP (one cycle): if the cells are uniform, add 1 to row 0 so the grid is guaranteed unsolved. Then go to IDLE and set busy = 0.
- scramble_start while not in IDLE: ignored.
- solved: registered. Reflects the cell array of the previous cycle, so it lags a cell change by 1 cycle.
- Wrap-around: max + 1 gives 0; 0 - 1 gives max.
- Reset mid-scramble: abort immediately and restore all reset values.

Optional Feature:
UNDO_EN
- With the macro: the last accepted in-range user move is recorded (is_col, index, sub).
  - An undo pulse in IDLE with a valid record applies the inverse move, decrements move_count (floor 0) and invalidates the record.
  - The record is invalidated by scramble or reset.
  - When undo and cmd_valid arrive in the same cycle, undo wins and cmd_ready = 0.
- Without the macro: the undo port is ignored, no record registers are built, and cmd_ready is as defined above.

Decomposition:
- Package grid_pkg holds:
  - FSM state enum;
  - LFSR_MASK = 16'hB400;
  - an idx_width(n) function;
  - a move struct {is_col, index, sub}.
- One sub-module, grid_lfsr: 16-bit Galois LFSR with seed parameter, synchronous reset, and always-on stepping.

Test Plan:
1. Reset, then row fire index 1 add (N=4, S=2) -> cells[15:8] = 8'h55, all other cells 0, solved = 0 one cycle later, move_count = 1.
2. Column 2 subtract on an all-zero grid -> cells (r,2) = 2'b11 for all r; repeat add on column 2 -> back to all zero, solved = 1, move_count = 2.
3. Four adds on row 0 -> row 0 wraps to 0, solved = 1, move_count = 4.
4. scramble_start with simultaneous cmd_valid -> cmd_ready = 0 that cycle; busy high for SCRAMBLE_MOVES + 1 cycles; afterwards solved = 0 and move_count = 0. Cells must match the reference model driven by the same LFSR sequence.
5. Reset asserted mid-scramble (cycle 5) -> next cycle cells = 0, busy = 0, LFSR = seed, solved = 1.
6. UNDO_EN: row 3 add, then undo -> grid all zero, move_count = 0; a second undo -> no change.
